hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use, branch-operand and MDU stalls, branch-slot flush,
// E-stage operand forwarding select, and the multiply/divide busy tracker.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] dst_E,
    input  logic [4:0] dst_M,
    input  logic [4:0] dst_W,
    input  logic       regwrite_E,
    input  logic       regwrite_M,
    input  logic       regwrite_W,
    input  logic       memread_E,
    input  logic       memread_M,
    input  logic       flush_D,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       md_use_D,
    output logic       nen_PC,
    output logic       nen_FD,
    output logic       clr_FD,
    output logic       clr_DE,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

    md_state_e  state_q;
    md_state_e  state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       load_use_s;
    logic       branch_s;
    logic       mdu_s;
    logic       stall_s;

    // M result is younger than W, so it wins when both target the operand.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic wr_m, input logic [4:0] d_m,
                                           input logic wr_w, input logic [4:0] d_w);
        logic [1:0] sel;
        if (wr_m && (d_m != 5'd0) && (d_m == src)) begin
            sel = 2'd1;
        end else if (wr_w && (d_w != 5'd0) && (d_w == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // MDU state and busy counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MDU next state; a start while busy is deliberately ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start_E) begin
                    if (md_is_div_E) begin
                        state_d = DIV;
                        cnt_d   = DIV_LOAD;
                    end else begin
                        state_d = MULT;
                        cnt_d   = MULT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MULT, DIV: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Stall, flush and forward decode; everything is forced quiet while in reset
    always_comb begin
        load_use_s = 1'b0;
        branch_s   = 1'b0;
        mdu_s      = 1'b0;
        stall_s    = 1'b0;
        md_busy    = 1'b0;
        nen_PC     = 1'b0;
        nen_FD     = 1'b0;
        clr_DE     = 1'b0;
        clr_FD     = 1'b0;
        fwd_rs_E   = 2'd0;
        fwd_rt_E   = 2'd0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            md_busy    = (state_q != IDLE);
            load_use_s = memread_E && (dst_E != 5'd0) &&
                         ((dst_E == rs_D) || (dst_E == rt_D));
            branch_s   = (use_rs_D && ((regwrite_E && (dst_E != 5'd0) && (dst_E == rs_D)) ||
                                       (memread_M  && (dst_M != 5'd0) && (dst_M == rs_D)))) ||
                         (use_rt_D && ((regwrite_E && (dst_E != 5'd0) && (dst_E == rt_D)) ||
                                       (memread_M  && (dst_M != 5'd0) && (dst_M == rt_D))));
            mdu_s      = md_use_D && (md_busy || md_start_E);
            stall_s    = load_use_s || branch_s || mdu_s;
            nen_PC     = stall_s;
            nen_FD     = stall_s;
            clr_DE     = stall_s;
            clr_FD     = flush_D && !stall_s;
            fwd_rs_E   = fwd_sel(rs_E, regwrite_M, dst_M, regwrite_W, dst_W);
            fwd_rt_E   = fwd_sel(rt_E, regwrite_M, dst_M, regwrite_W, dst_W);
        end
    end

endmodule
